// File: rtl/cmp_pkg.sv
// Shared types and helpers for the comparator crossing detector:
// relation encoding, rank constants and the flag decoder.
package cmp_pkg;

  typedef enum logic [1:0] {
    REL_UNKNOWN = 2'd0,
    REL_LOW     = 2'd1,
    REL_EQ      = 2'd2,
    REL_HIGH    = 2'd3
  } rel_t;

  localparam logic [1:0] RANK_LOW  = 2'd1;
  localparam logic [1:0] RANK_EQ   = 2'd2;
  localparam logic [1:0] RANK_HIGH = 2'd3;

  typedef struct packed {
    logic illegal;
    rel_t cls;
  } dec_t;

  function automatic dec_t decode_flags(input logic gt, input logic eq, input logic lt);
    dec_t d;
    d.illegal = 1'b0;
    d.cls     = REL_UNKNOWN;
    case ({gt, eq, lt})
      3'b100:  d.cls = REL_HIGH;
      3'b010:  d.cls = REL_EQ;
      3'b001:  d.cls = REL_LOW;
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  function automatic logic [1:0] rank_of(input rel_t r);
    logic [1:0] k;
    case (r)
      REL_LOW:  k = RANK_LOW;
      REL_EQ:   k = RANK_EQ;
      REL_HIGH: k = RANK_HIGH;
      default:  k = 2'd0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/cmp_cross_detector_if.sv
// Sample/result bundle of the crossing detector.
// evt_ts exists only when CMP_TIMESTAMP_EN is defined.
interface cmp_cross_detector_if #(
  parameter int CNT_W = 8
`ifdef CMP_TIMESTAMP_EN
  , parameter int TS_W = 16
`endif
);
  logic             in_valid;
  logic             greater;
  logic             lesser;
  logic             equal;
  logic [1:0]       state;
  logic             state_valid;
  logic             rise_evt;
  logic             fall_evt;
  logic [CNT_W-1:0] evt_cnt;
  logic             err;
`ifdef CMP_TIMESTAMP_EN
  logic [TS_W-1:0]  evt_ts;
`endif

  modport master (
`ifdef CMP_TIMESTAMP_EN
    input  evt_ts,
`endif
    output in_valid, greater, lesser, equal,
    input  state, state_valid, rise_evt, fall_evt, evt_cnt, err
  );

  modport slave (
`ifdef CMP_TIMESTAMP_EN
    output evt_ts,
`endif
    input  in_valid, greater, lesser, equal,
    output state, state_valid, rise_evt, fall_evt, evt_cnt, err
  );
endinterface

// File: rtl/cmp_debounce.sv
// Candidate/run tracker: strobes o_stable when an accepted sample makes the
// run of identical classes reach DEBOUNCE; o_cls is the candidate class.
module cmp_debounce
  import cmp_pkg::*;
#(
  parameter int DEBOUNCE = 3
)(
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_valid,
  input  logic i_illegal,
  input  rel_t i_cls,
  output logic o_stable,
  output rel_t o_cls
);

  localparam logic [3:0] RUN_MAX = 4'(DEBOUNCE);

  rel_t       r_cand, w_cand_nxt;
  logic [3:0] r_run,  w_run_nxt;
  logic       w_accept;

  assign w_accept = i_valid && !i_illegal && !i_clr;

  always_comb begin
    w_cand_nxt = r_cand;
    w_run_nxt  = r_run;
    if (w_accept) begin
      if (i_cls == r_cand) begin
        w_run_nxt = (r_run >= RUN_MAX) ? RUN_MAX : r_run + 4'd1;
      end else begin
        w_cand_nxt = i_cls;
        w_run_nxt  = 4'd1;
      end
    end
  end

  assign o_stable = w_accept && (w_run_nxt == RUN_MAX);
  assign o_cls    = w_cand_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand <= REL_UNKNOWN;
      r_run  <= 4'd0;
    end else if (i_clr) begin
      r_cand <= REL_UNKNOWN;
      r_run  <= 4'd0;
    end else begin
      r_cand <= w_cand_nxt;
      r_run  <= w_run_nxt;
    end
  end

endmodule

// File: rtl/cmp_cross_detector.sv
// Debounced relation FSM with rise/fall crossing events, saturating event
// counter and sticky illegal-flag error. CMP_TIMESTAMP_EN adds evt_ts.
module cmp_cross_detector
  import cmp_pkg::*;
#(
  parameter int DEBOUNCE = 3,
  parameter int CNT_W    = 8
`ifdef CMP_TIMESTAMP_EN
  , parameter int TS_W   = 16
`endif
)(
  input logic                 clk,
  input logic                 rst_n,
  input logic                 clr,
  cmp_cross_detector_if.slave bus
);

  dec_t             w_dec;
  logic             w_stable;
  rel_t             w_cls;
  rel_t             r_state, w_state_nxt;
  logic             w_rise, w_fall;
  logic             r_rise, r_fall, r_err;
  logic [CNT_W-1:0] r_cnt;
  logic             w_illegal;

  assign w_dec     = decode_flags(bus.greater, bus.equal, bus.lesser);
  assign w_illegal = bus.in_valid && w_dec.illegal && !clr;

  cmp_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (clr),
    .i_valid   (bus.in_valid),
    .i_illegal (w_dec.illegal),
    .i_cls     (w_dec.cls),
    .o_stable  (w_stable),
    .o_cls     (w_cls)
  );

  // Leaving UNKNOWN only settles the FSM; later moves are ranked into rise/fall.
  always_comb begin
    w_state_nxt = r_state;
    w_rise      = 1'b0;
    w_fall      = 1'b0;
    if (w_stable && (w_cls != r_state)) begin
      w_state_nxt = w_cls;
      if (r_state != REL_UNKNOWN) begin
        if (rank_of(w_cls) > rank_of(r_state)) w_rise = 1'b1;
        else                                   w_fall = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= REL_UNKNOWN;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else if (clr) begin
      r_state <= REL_UNKNOWN;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rise  <= w_rise;
      r_fall  <= w_fall;
      if ((w_rise || w_fall) && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
      if (w_illegal) r_err <= 1'b1;
    end
  end

  assign bus.state       = r_state;
  assign bus.state_valid = (r_state != REL_UNKNOWN);
  assign bus.rise_evt    = r_rise;
  assign bus.fall_evt    = r_fall;
  assign bus.evt_cnt     = r_cnt;
  assign bus.err         = r_err;

`ifdef CMP_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts, r_evt_ts;

  // Free-running counter survives clr; only rst_n clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ts     <= '0;
      r_evt_ts <= '0;
    end else begin
      r_ts <= r_ts + 1'b1;
      if (w_rise || w_fall) r_evt_ts <= r_ts;
    end
  end

  assign bus.evt_ts = r_evt_ts;
`endif

endmodule
